// File: rtl/ps2_keymap_fifo.sv
// PS/2 set-2 make-code to ASCII translator feeding a first-word-fall-through FIFO.
// Optional caps-lock tracking is compiled in with `define PS2_KEYMAP_CAPS_EN.
module ps2_keymap_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               code,
  input  logic                     code_valid,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     shift_st,
  output logic                     caps_st
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_make, w_brk;
  logic             r_lsh, r_rsh;
  logic             w_caps;
  logic [8:0]       w_xlate;
  logic             r_vld_p1;
  logic [7:0]       r_char_p1;
  logic [PW-1:0]    r_wr, r_rd;
  logic             w_full, w_empty, w_push, w_pop;
  logic             r_ovf;
  logic [7:0]       r_mem [DEPTH];

  // Letter lookup; returns 0x00 for anything that is not a letter key.
  function automatic logic [7:0] f_letter(input logic [7:0] c);
    logic [7:0] l;
    l = 8'h00;
    case (c)
      8'h1C: l = 8'h61;  8'h32: l = 8'h62;  8'h21: l = 8'h63;  8'h23: l = 8'h64;
      8'h24: l = 8'h65;  8'h2B: l = 8'h66;  8'h34: l = 8'h67;  8'h33: l = 8'h68;
      8'h43: l = 8'h69;  8'h3B: l = 8'h6A;  8'h42: l = 8'h6B;  8'h4B: l = 8'h6C;
      8'h3A: l = 8'h6D;  8'h31: l = 8'h6E;  8'h44: l = 8'h6F;  8'h4D: l = 8'h70;
      8'h15: l = 8'h71;  8'h2D: l = 8'h72;  8'h1B: l = 8'h73;  8'h2C: l = 8'h74;
      8'h3C: l = 8'h75;  8'h2A: l = 8'h76;  8'h1D: l = 8'h77;  8'h22: l = 8'h78;
      8'h35: l = 8'h79;  8'h1A: l = 8'h7A;
      default: l = 8'h00;
    endcase
    return l;
  endfunction

  // Digit row and the fixed control keys; shift selects the symbol row.
  function automatic logic [7:0] f_other(input logic [7:0] c, input logic sh);
    logic [7:0] d;
    d = 8'h00;
    case (c)
      8'h16: d = sh ? 8'h21 : 8'h31;
      8'h1E: d = sh ? 8'h40 : 8'h32;
      8'h26: d = sh ? 8'h23 : 8'h33;
      8'h25: d = sh ? 8'h24 : 8'h34;
      8'h2E: d = sh ? 8'h25 : 8'h35;
      8'h36: d = sh ? 8'h5E : 8'h36;
      8'h3D: d = sh ? 8'h26 : 8'h37;
      8'h3E: d = sh ? 8'h2A : 8'h38;
      8'h46: d = sh ? 8'h28 : 8'h39;
      8'h45: d = sh ? 8'h29 : 8'h30;
      8'h29: d = 8'h20;
      8'h5A: d = 8'h0D;
      8'h66: d = 8'h08;
      8'h76: d = 8'h1B;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  // Returns {hit, ascii}; hit=0 for unmapped keys (every mapped char is non-zero).
  function automatic logic [8:0] f_xlate(input logic [7:0] c, input logic up,
                                         input logic sh);
    logic [7:0] l, o;
    l = f_letter(c);
    o = f_other(c, sh);
    if (l != 8'h00)      return {1'b1, up ? (l - 8'h20) : l};
    else if (o != 8'h00) return {1'b1, o};
    else                 return 9'h000;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    if (code_valid) begin
      case (r_state)
        S_IDLE: begin
          if (code == 8'hF0)      w_state_nxt = S_BRK;
          else if (code == 8'hE0) w_state_nxt = S_EXT;
          else                    w_make      = 1'b1;
        end
        S_BRK: begin
          w_brk       = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_EXT:     w_state_nxt = (code == 8'hF0) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsh <= 1'b0;
      r_rsh <= 1'b0;
    end else begin
      if ((w_make || w_brk) && code == 8'h12) r_lsh <= w_make;
      if ((w_make || w_brk) && code == 8'h59) r_rsh <= w_make;
    end
  end

  assign shift_st = r_lsh | r_rsh;

`ifdef PS2_KEYMAP_CAPS_EN
  logic r_caps, r_caps_held;

  // caps_held suppresses re-toggling on typematic repeats of the caps key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else if (code == 8'h58) begin
      if (w_make) begin
        if (!r_caps_held) r_caps <= ~r_caps;
        r_caps_held <= 1'b1;
      end else if (w_brk) begin
        r_caps_held <= 1'b0;
      end
    end
  end

  assign caps_st = r_caps;
`else
  assign caps_st = 1'b0;
`endif

  assign w_caps  = caps_st;
  assign w_xlate = f_xlate(code, shift_st ^ w_caps, shift_st);

  // ---- stage p1: translated char and push strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= w_make && w_xlate[8];
  end

  always_ff @(posedge clk) begin
    if (w_make) r_char_p1 <= w_xlate[7:0];
  end

  // ---- FIFO: pointers carry a wrap bit to tell full from empty ----
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
  assign w_pop   = rd_en && !w_empty;
  assign w_push  = r_vld_p1 && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (r_vld_p1 && w_full && !w_pop) r_ovf <= 1'b1;
      else if (clr_ovf)                 r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= r_char_p1;
  end

  assign rd_valid = !w_empty;
  assign rd_data  = w_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
  assign count    = r_wr - r_rd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_ps2_keymap_fifo.sv
// Directed bench for ps2_keymap_fifo (DEPTH=8); follows PS2_KEYMAP_CAPS_EN like the DUT.
module tb_ps2_keymap_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] code;
  logic       code_valid;
  logic       rd_en;
  logic       clr_ovf;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       overflow;
  logic       shift_st;
  logic       caps_st;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_keymap_fifo #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .code_valid (code_valid),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .overflow   (overflow),
    .shift_st   (shift_st),
    .caps_st    (caps_st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left on a falling edge.
  task automatic send(input logic [7:0] c);
    code       = c;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; code = 8'h00; code_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    idle(2);
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_overflow", overflow, 0);
    chk("rst_shift", shift_st, 0);
    chk("rst_caps", caps_st, 0);
    rst_n = 1'b1;
    idle(1);

    // single make, FWFT read
    send(8'h1C);
    chk("lat_count_pre", count, 0);
    idle(1);
    chk("a_valid", rd_valid, 1);
    chk("a_data", rd_data, 8'h61);
    chk("a_count", count, 1);
    pop();
    chk("a_pop_valid", rd_valid, 0);
    chk("a_pop_data", rd_data, 8'h00);
    chk("a_pop_count", count, 0);

    // shift make/break around letters
    send(8'h12);
    chk("shift_on", shift_st, 1);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("shift_off", shift_st, 0);
    send(8'h1C);
    idle(1);
    chk("sh_count", count, 2);
    chk("sh_head0", rd_data, 8'h41);
    pop();
    chk("sh_head1", rd_data, 8'h61);
    pop();
    chk("sh_empty", count, 0);

    // digits with/without shift, enter
    send(8'h45); send(8'h12); send(8'h45); send(8'hF0); send(8'h12); send(8'h5A);
    idle(1);
    chk("dg_count", count, 3);
    chk("dg_zero", rd_data, 8'h30);
    pop();
    chk("dg_rparen", rd_data, 8'h29);
    pop();
    chk("dg_enter", rd_data, 8'h0D);
    pop();

`ifdef PS2_KEYMAP_CAPS_EN
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_on", caps_st, 1);
    send(8'h1C); send(8'h12); send(8'h1C); send(8'h16);
    idle(1);
    chk("caps_count", count, 3);
    chk("caps_A", rd_data, 8'h41);
    pop();
    chk("caps_shift_a", rd_data, 8'h61);
    pop();
    chk("caps_bang", rd_data, 8'h21);
    pop();
    send(8'hF0); send(8'h12); send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_off", caps_st, 0);
    chk("caps_shift_rel", shift_st, 0);
`else
    send(8'h58);
    idle(1);
    chk("nocaps_count", count, 0);
    chk("nocaps_caps", caps_st, 0);
    send(8'h1C);
    idle(1);
    chk("nocaps_a", rd_data, 8'h61);
    pop();
`endif

    // extended make/break discarded, FSM returns to IDLE
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h29);
    idle(1);
    chk("ext_count", count, 1);
    chk("ext_space", rd_data, 8'h20);
    pop();
    send(8'h1C);
    idle(1);
    chk("ext_idle_a", rd_data, 8'h61);
    pop();

    // overflow with nine pushes into DEPTH=8
    repeat (9) send(8'h1C);
    idle(1);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);
    // push lands on the edge where the pop is sampled, while full
    code = 8'h1C; code_valid = 1'b1;
    idle(1);
    code_valid = 1'b0; rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
    chk("pp_count", count, 8);
    chk("pp_ovf", overflow, 0);
    // clear coinciding with a fresh overflow
    code = 8'h1C; code_valid = 1'b1;
    idle(1);
    code_valid = 1'b0; clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("clr_vs_set", overflow, 1);
    chk("clr_vs_set_cnt", count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", rd_data, 8'h61);
      pop();
    end
    chk("drain_valid", rd_valid, 0);
    chk("drain_count", count, 0);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("ovf_clr2", overflow, 0);

    // asynchronous reset mid-prefix with entries queued
`ifdef PS2_KEYMAP_CAPS_EN
    send(8'h58);
    chk("pre_rst_caps", caps_st, 1);
`endif
    send(8'h12); send(8'h1C); send(8'h1C); send(8'h1C);
    idle(1);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_shift", shift_st, 1);
    send(8'hF0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_data", rd_data, 8'h00);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_shift", shift_st, 0);
    chk("mid_rst_caps", caps_st, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send(8'h1C);
    idle(1);
    chk("post_rst_count", count, 1);
    chk("post_rst_a", rd_data, 8'h61);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keymap_fifo.md
# ps2_keymap_fifo

Downstream of the PS/2 scan-code decoder. Consumes single-cycle scan-code strobes (set 2), tracks break/extended prefixes and modifier state (shift, caps lock), translates make codes to ASCII and queues them in a first-word-fall-through FIFO read by the CPU-side MMIO register. Break codes, extended keys and unmapped keys produce no FIFO entry.

## Interface
- `DEPTH`, default 8. FIFO entries; power of two, 2..64.
- `clk`  in  1  system clock, same domain as the decoder.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `code`  in  8  scan code from the decoder.
- `code_valid`  in  1  one-cycle strobe; `code` is valid when high.
- `rd_en`  in  1  pop head entry; ignored when `rd_valid`=0.
- `clr_ovf`  in  1  clears `overflow`.
- `rd_data`  out  8  ASCII at FIFO head (FWFT); 0x00 when empty.
- `rd_valid`  out  1  FIFO not empty.
- `count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a translated char is dropped because the FIFO is full.
- `shift_st`  out  1  left or right shift currently held.
- `caps_st`  out  1  caps-lock toggle state.

## Operation
- Prefix FSM, advances only on `code_valid`:
  - IDLE: F0 -> BRK; E0 -> EXT; other -> handle make, stay IDLE.
  - BRK: handle break of `code` -> IDLE.
  - EXT: F0 -> EXT_BRK; other -> discard -> IDLE.
  - EXT_BRK: discard -> IDLE.
- Modifiers: make 12 or 59 sets its own held bit (`lsh`, `rsh`); break clears it; `shift_st` = `lsh`|`rsh`. Make 58 toggles caps only when `caps_held`=0, then sets `caps_held`; break 58 clears `caps_held` (typematic repeats never re-toggle). Modifier codes never enqueue.
- Make translation:
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Uppercase (subtract 0x20) when `shift_st` XOR `caps_st`.
  - Digits: 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9, 45 0. With shift: ! @ # $ % ^ & * ( ). Caps has no effect.
  - 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08, 76 -> 0x1B; unaffected by modifiers.
  - Anything else: dropped, no flag.
- Typematic repeat of a mapped make enqueues again each time.
- FIFO: circular buffer, wr/rd pointers of $clog2(DEPTH)+1 bits with wrap bit; full when indices equal and wrap bits differ.
  - Push while full: char dropped, `overflow`<=1, contents unchanged.
  - Push and pop in the same cycle: both occur, including when full (no overflow) and when empty-with-pending-push is impossible (push lands first, pop ignored since `rd_valid`=0).
  - `clr_ovf` and a new overflow in the same cycle: `overflow` stays 1.
- Reset (any time, including mid-prefix): FSM IDLE, pointers 0, `count`=0, `rd_valid`=0, `rd_data`=0x00, `overflow`=0, `shift_st`=0, `caps_st`=0, `caps_held`=0.

## Timing
- Translation stage registered: `code_valid` sampled at edge k -> char + push strobe registered at k -> FIFO written at edge k+1 -> `rd_valid`/`rd_data`/`count` updated after edge k+1.
- Modifier outputs update after edge k.
- Back-to-back `code_valid` on consecutive cycles sustained at one code per cycle.
- `rd_en` sampled at edge m while `rd_valid`=1: head advances, `count` decrements after edge m; next head visible same cycle.

## Configuration
- `PS2_KEYMAP_CAPS_EN` defined: caps-lock tracking as above, `caps_st` driven from the toggle register.
- Not defined: code 58 treated as an unmapped key (dropped), no caps register, `caps_st` tied 0, letter case depends on shift only.

## Test plan
- Reset, strobe 1C -> one entry, `rd_data`=0x61 two edges later, `count`=1; `rd_en` -> `rd_valid`=0, `rd_data`=0x00.
- Sequence 12,1C,F0,1C,F0,12,1C -> FIFO holds 0x41, 0x61; `shift_st` 1 then 0; break codes enqueue nothing.
- Caps (macro on): 58,58,F0,58,1C,12,1C,16 -> `caps_st`=1 once, FIFO 0x41, 0x61, 0x21; macro off: 58 enqueues nothing, 1C -> 0x61.
- E0,75,E0,F0,75,29 -> only 0x20 queued; FSM back in IDLE.
- DEPTH=8: nine 1C strobes no reads -> `count`=8, `overflow`=1, all entries 0x61; push+pop same cycle while full -> `count` stays 8, `overflow` unchanged; `clr_ovf` -> 0.
- Assert `rst_n` low after F0 with 3 entries queued -> all outputs reset values; next 1C -> 0x61 (not treated as break).
